alu_muldiv: RTL

ALU_MULDIV -- requirements
Module: alu_muldiv

---
 rtl/alu_muldiv.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/alu_muldiv.sv
// rtl/alu_muldiv.sv - iterative RV32M multiply/divide unit with tagged valid/ready handshake
// Divider hardware is present only when ALU_MULDIV_DIV_EN is defined.
module alu_muldiv #(
  parameter int N_BITS = 32,
  parameter int TAG_W  = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        op,
  input  logic [N_BITS-1:0] in0,
  input  logic [N_BITS-1:0] in1,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N_BITS-1:0] out,
  output logic [TAG_W-1:0]  out_tag,
  output logic              out_err
);
  localparam int CW = $clog2(N_BITS) + 1;
  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_REM    = 3'd6;

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;
  state_t state, state_nxt;

  logic [2*N_BITS-1:0] acc, step_nxt, mul_nxt, mul_fin;
  logic [N_BITS:0]     mul_sum;
  logic [N_BITS-1:0]   opb, abs0, abs1, fast_res, fin_res;
  logic [2:0]          op_q;
  logic [CW-1:0]       cnt;
  logic                neg_q, neg_in, a_signed, b_signed;
  logic                fast, fast_err, accept, last;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = (state == IDLE) && in_valid && !flush;
  assign last      = (cnt == CW'(N_BITS - 1));

  always_comb begin
    a_signed = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    b_signed = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    abs0     = (a_signed && in0[N_BITS-1]) ? -in0 : in0;
    abs1     = (b_signed && in1[N_BITS-1]) ? -in1 : in1;
    // a remainder carries the dividend's sign only
    neg_in   = (a_signed && in0[N_BITS-1]) ^ (b_signed && in1[N_BITS-1] && (op != OP_REM));
  end

  always_comb begin
    fast     = 1'b0;
    fast_err = 1'b0;
    fast_res = '0;
`ifdef ALU_MULDIV_DIV_EN
    if (op[2]) begin
      if (in1 == '0) begin
        fast     = 1'b1;
        fast_res = op[1] ? in0 : '1;
      end else if (!op[0] && (in0 == {1'b1, {(N_BITS-1){1'b0}}}) && (in1 == '1)) begin
        fast     = 1'b1;
        fast_res = op[1] ? '0 : in0;
      end
    end
`else
    if (op[2]) begin
      fast     = 1'b1;
      fast_err = 1'b1;
    end
`endif
  end

`ifdef ALU_MULDIV_DIV_EN
  logic [N_BITS:0]     rem_sh, diff;
  logic [2*N_BITS-1:0] div_nxt;
  logic [N_BITS-1:0]   div_res;
`endif

  // acc holds {partial product, multiplier} or {remainder, dividend/quotient}
  always_comb begin
    mul_sum  = {1'b0, acc[2*N_BITS-1:N_BITS]} + (acc[0] ? {1'b0, opb} : '0);
    mul_nxt  = {mul_sum, acc[N_BITS-1:1]};
    mul_fin  = neg_q ? -mul_nxt : mul_nxt;
    step_nxt = mul_nxt;
    fin_res  = (op_q == OP_MUL) ? mul_fin[N_BITS-1:0] : mul_fin[2*N_BITS-1:N_BITS];
`ifdef ALU_MULDIV_DIV_EN
    rem_sh  = {acc[2*N_BITS-1:N_BITS], acc[N_BITS-1]};
    diff    = rem_sh - {1'b0, opb};
    div_nxt = diff[N_BITS] ? {rem_sh[N_BITS-1:0], acc[N_BITS-2:0], 1'b0}
                           : {diff[N_BITS-1:0], acc[N_BITS-2:0], 1'b1};
    div_res = op_q[1] ? div_nxt[2*N_BITS-1:N_BITS] : div_nxt[N_BITS-1:0];
    if (op_q[2]) begin
      step_nxt = div_nxt;
      fin_res  = neg_q ? -div_res : div_res;
    end
`endif
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = fast ? DONE : BUSY;
      BUSY:    if (flush) state_nxt = IDLE;
               else if (last) state_nxt = DONE;
      DONE:    if (flush || out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      acc     <= '0;
      opb     <= '0;
      op_q    <= '0;
      neg_q   <= 1'b0;
      cnt     <= '0;
      out     <= '0;
      out_tag <= '0;
      out_err <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        op_q    <= op;
        neg_q   <= neg_in;
        acc     <= {{N_BITS{1'b0}}, abs0};
        opb     <= abs1;
        cnt     <= '0;
        out_tag <= in_tag;
        out_err <= fast_err;
        if (fast) out <= fast_res;
      end else if ((state == BUSY) && !flush) begin
        acc <= step_nxt;
        cnt <= cnt + 1'b1;
        if (last) out <= fin_res;
      end
    end
  end
endmodule
